instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Front end of the single-issue RV32I core: owns the program counter (PC) and drives
//   read_addr into the combinational instruction memory, which returns instruction the same cycle.
//   Captures each {pc, instruction} into the IF/ID pipeline register for the decoder.
//   Handles stall, branch redirect/flush, and halt on an empty instruction word.
// PARAMETERS
//   ADDR_W    10            width of PC / word address into instruction memory
//   XLEN      32            instruction width
//   RESET_PC  10'd0         word address fetched first after reset
//   NOP       32'h00000013  bubble encoding (addi x0,x0,0) loaded into IF/ID on flush
// PORTS
//   clk            in   1       rising-edge clock
//   rst_n          in   1       asynchronous, active-low reset
//   stall          in   1       hazard unit: hold PC and IF/ID this cycle
//   branch_taken   in   1       EX stage: redirect fetch this cycle
//   branch_target  in   ADDR_W  word address to redirect to
//   read_addr      out  ADDR_W  to instruction memory; combinational copy of pc_q
//   instruction    in   XLEN    from instruction memory; valid same cycle as read_addr
//   ifid_instr     out  XLEN    IF/ID registered instruction
//   ifid_pc        out  ADDR_W  IF/ID registered word address of ifid_instr
//   ifid_valid     out  1       ifid_instr is a real fetched instruction
//   halted         out  1       fetch stopped (HALT state)
//   fetch_count    out  16      number of instructions written into IF/ID, saturating
// BEHAVIOUR
//   Reset (async, rst_n=0): pc_q=RESET_PC, ifid_instr=NOP, ifid_pc=0, ifid_valid=0,
//     halted=0, fetch_count=0, state=BOOT. Applies immediately, mid-operation included.
//   FSM states: BOOT, RUN, HALT.
//     BOOT: one cycle after reset release; pc_q held, ifid_valid stays 0; -> RUN unconditionally.
//     RUN: per-cycle priority, highest first:
//       1 branch_taken: pc_q<=branch_target; ifid_instr<=NOP, ifid_valid<=0 (flush).
//         Overrides stall and halt detection in the same cycle.
//       2 stall: pc_q, ifid_*, fetch_count all hold.
//       3 instruction==32'h0: -> HALT; ifid_instr<=NOP, ifid_valid<=0; pc_q holds.
//       4 else: ifid_instr<=instruction, ifid_pc<=pc_q, ifid_valid<=1,
//         pc_q<=pc_q+1 mod 2^ADDR_W (1023 wraps to 0), fetch_count+=1 (saturates at 16'hFFFF).
//     HALT: halted=1; pc_q, ifid_instr, ifid_pc and fetch_count frozen; ifid_valid=0.
//       Exit only by reset; branch_taken and stall are ignored.
//   Latency: instruction at pc_q appears on ifid_* one clock edge after it is addressed.
//   First valid IF/ID entry appears two edges after reset release (BOOT + fetch).
//   read_addr = pc_q at all times (no combinational path from branch_target to read_addr).
//   A branch_target beyond the populated memory range is fetched as-is; no range check.
// TESTING
//   1 Reset, imem[0..3] = add/sub/or/and, no stall -> edge 2: ifid_pc=0, ifid_instr=32'h002080B3,
//     valid=1; edges 3-5: pc 1,2,3 in order; fetch_count=4.
//   2 stall=1 for 3 cycles while pc_q=2 -> read_addr stays 2, ifid_pc stays 1, count unchanged;
//     resumes with ifid_pc=2.
//   3 branch_taken=1 and stall=1 together, target=10'd5 at pc_q=3 -> next edge: ifid_instr=NOP,
//     valid=0, read_addr=5; following edge: ifid_pc=5.
//   4 imem[6]=0 after beq at 5 -> at pc 6: halted=1, ifid_valid=0, read_addr stuck at 6;
//     a branch_taken pulse has no effect.
//   5 Redirect to 10'd1023, imem[1023] nonzero -> ifid_pc=1023, then read_addr wraps to 0.
//   6 rst_n low mid-run (async, between edges) -> all outputs at reset values immediately;
//     restart fetches from RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//   Fetch stage of the single-issue RV32I core. It owns the program counter and
//   addresses a combinational instruction memory, which returns the instruction
//   in the same cycle. Each fetched {pc, instruction} pair is captured into the
//   IF/ID pipeline register. The stage also handles hazard stalls, branch
//   redirect with flush, and a terminal halt when the fetched word is zero.
//
//   Control flow:
//     BOOT : the single cycle after reset release. The PC holds and no
//            instruction is captured.
//     RUN  : normal fetch. Per-cycle priority is branch > stall > zero-word
//            halt > fetch.
//     HALT : everything is frozen until the next reset.
//
//   Every architectural output comes straight from a flop. read_addr is a
//   direct copy of the PC register, so branch_target never reaches the memory
//   address combinationally.
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
    parameter int                ADDR_W   = 10,
    parameter int                XLEN     = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 10'd0,
    parameter logic [XLEN-1:0]   NOP      = 32'h00000013
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] read_addr,
    input  logic [XLEN-1:0]   instruction,
    output logic [XLEN-1:0]   ifid_instr,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic              ifid_valid,
    output logic              halted,
    output logic [15:0]       fetch_count
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_t;

    localparam logic [15:0]       COUNT_MAX = 16'hFFFF;
    localparam logic [15:0]       COUNT_ONE = 16'h0001;
    localparam logic [ADDR_W-1:0] PC_ONE    = ADDR_W'(1);
    localparam logic [XLEN-1:0]   ZERO_WORD = '0;

    // -------------------------------------------------------------------------
    // Registered state
    // -------------------------------------------------------------------------
    fetch_state_t      state_r;
    logic [ADDR_W-1:0] pc_r;
    logic [XLEN-1:0]   ifid_instr_r;
    logic [ADDR_W-1:0] ifid_pc_r;
    logic              ifid_valid_r;
    logic              halted_r;
    logic [15:0]       fetch_count_r;

    // -------------------------------------------------------------------------
    // Next-state values
    // -------------------------------------------------------------------------
    fetch_state_t      state_s;
    logic [ADDR_W-1:0] pc_s;
    logic [XLEN-1:0]   ifid_instr_s;
    logic [ADDR_W-1:0] ifid_pc_s;
    logic              ifid_valid_s;
    logic              halted_s;
    logic [15:0]       fetch_count_s;

    // Decoded per-cycle conditions, used only while in RUN
    logic              word_is_zero_s;
    logic              count_at_max_s;

    // Saturating increment of the fetch counter: it sticks at all-ones.
    function automatic logic [15:0] sat_inc16(input logic [15:0] value);
        logic [15:0] result;
        if (value == COUNT_MAX) begin
            result = COUNT_MAX;
        end else begin
            result = value + COUNT_ONE;
        end
        return result;
    endfunction

    // Sequential word-address increment. It wraps naturally at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] pc_inc(input logic [ADDR_W-1:0] value);
        return value + PC_ONE;
    endfunction

    // Decode the conditions that steer the RUN-state priority chain.
    always_comb begin
        word_is_zero_s = 1'b0;
        count_at_max_s = 1'b0;
        if (instruction == ZERO_WORD) begin
            word_is_zero_s = 1'b1;
        end else begin
            word_is_zero_s = 1'b0;
        end
        if (fetch_count_r == COUNT_MAX) begin
            count_at_max_s = 1'b1;
        end else begin
            count_at_max_s = 1'b0;
        end
    end

    // State register for the fetch controller.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state and next-datapath logic; hold every value unless a rule changes it.
    always_comb begin
        state_s       = state_r;
        pc_s          = pc_r;
        ifid_instr_s  = ifid_instr_r;
        ifid_pc_s     = ifid_pc_r;
        ifid_valid_s  = ifid_valid_r;
        halted_s      = halted_r;
        fetch_count_s = fetch_count_r;

        case (state_r)
            ST_BOOT: begin
                // The first fetch happens on the edge after this one.
                ifid_valid_s = 1'b0;
                halted_s     = 1'b0;
                state_s      = ST_RUN;
            end

            ST_RUN: begin
                if (branch_taken) begin
                    // Redirect and flush. This wins over a stall and over a
                    // zero word fetched in the same cycle. ifid_pc keeps its
                    // value because the bubble carries no address.
                    pc_s         = branch_target;
                    ifid_instr_s = NOP;
                    ifid_valid_s = 1'b0;
                end else if (stall) begin
                    // Hazard hold: PC, IF/ID and the counter keep their values.
                    pc_s          = pc_r;
                    ifid_instr_s  = ifid_instr_r;
                    ifid_pc_s     = ifid_pc_r;
                    ifid_valid_s  = ifid_valid_r;
                    fetch_count_s = fetch_count_r;
                end else if (word_is_zero_s) begin
                    // An empty word ends the program. The PC stays on it.
                    state_s      = ST_HALT;
                    halted_s     = 1'b1;
                    ifid_instr_s = NOP;
                    ifid_valid_s = 1'b0;
                end else begin
                    // Normal fetch into IF/ID.
                    ifid_instr_s = instruction;
                    ifid_pc_s    = pc_r;
                    ifid_valid_s = 1'b1;
                    pc_s         = pc_inc(pc_r);
                    if (count_at_max_s) begin
                        fetch_count_s = COUNT_MAX;
                    end else begin
                        fetch_count_s = sat_inc16(fetch_count_r);
                    end
                end
            end

            ST_HALT: begin
                // Terminal state: only reset leaves it. Branch and stall are ignored.
                halted_s     = 1'b1;
                ifid_valid_s = 1'b0;
                state_s      = ST_HALT;
            end

            default: begin
                // Unreachable encoding: fall back to a safe, restartable state.
                state_s      = ST_BOOT;
                pc_s         = RESET_PC;
                ifid_instr_s = NOP;
                ifid_valid_s = 1'b0;
                halted_s     = 1'b0;
            end
        endcase
    end

    // Program counter and IF/ID pipeline register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r         <= RESET_PC;
            ifid_instr_r <= NOP;
            ifid_pc_r    <= '0;
            ifid_valid_r <= 1'b0;
        end else begin
            pc_r         <= pc_s;
            ifid_instr_r <= ifid_instr_s;
            ifid_pc_r    <= ifid_pc_s;
            ifid_valid_r <= ifid_valid_s;
        end
    end

    // Halt flag and the saturating count of instructions written into IF/ID.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            halted_r      <= 1'b0;
            fetch_count_r <= 16'h0000;
        end else begin
            halted_r      <= halted_s;
            fetch_count_r <= fetch_count_s;
        end
    end

    // -------------------------------------------------------------------------
    // Output mapping: every output is a flop, and read_addr mirrors the PC.
    // -------------------------------------------------------------------------
    assign read_addr   = pc_r;
    assign ifid_instr  = ifid_instr_r;
    assign ifid_pc     = ifid_pc_r;
    assign ifid_valid  = ifid_valid_r;
    assign halted      = halted_r;
    assign fetch_count = fetch_count_r;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch_unit
//   Directed bench for instruction_fetch_unit. A combinational instruction
//   memory array drives the DUT. Expected values are worked out by hand from
//   the fetch rules.
// -----------------------------------------------------------------------------
module tb_instruction_fetch_unit;

    localparam logic [31:0] NOP_W  = 32'h00000013;
    localparam logic [31:0] I_ADD  = 32'h002080B3;
    localparam logic [31:0] I_SUB  = 32'h402080B3;
    localparam logic [31:0] I_OR   = 32'h0020E0B3;
    localparam logic [31:0] I_AND  = 32'h0020F0B3;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_TOP  = 32'h12345093;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [9:0]  branch_target;
    logic [9:0]  read_addr;
    logic [31:0] instruction;
    logic [31:0] ifid_instr;
    logic [9:0]  ifid_pc;
    logic        ifid_valid;
    logic        halted;
    logic [15:0] fetch_count;

    logic [31:0] imem [0:1023];

    int total;
    int bad;

    instruction_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .read_addr     (read_addr),
        .instruction   (instruction),
        .ifid_instr    (ifid_instr),
        .ifid_pc       (ifid_pc),
        .ifid_valid    (ifid_valid),
        .halted        (halted),
        .fetch_count   (fetch_count)
    );

    assign instruction = imem[read_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [9:0] ra, input logic [31:0] ins,
                           input logic [9:0] pc, input logic v, input logic h,
                           input logic [15:0] cnt);
        chk({tag, ".read_addr"},   {22'd0, read_addr},   {22'd0, ra});
        chk({tag, ".ifid_instr"},  ifid_instr,           ins);
        chk({tag, ".ifid_pc"},     {22'd0, ifid_pc},     {22'd0, pc});
        chk({tag, ".ifid_valid"},  {31'd0, ifid_valid},  {31'd0, v});
        chk({tag, ".halted"},      {31'd0, halted},      {31'd0, h});
        chk({tag, ".fetch_count"}, {16'd0, fetch_count}, {16'd0, cnt});
    endtask

    initial begin
        total = 0;
        bad   = 0;
        for (int i = 0; i < 1024; i++) imem[i] = 32'h00000013 + (i << 7);
        imem[0]    = I_ADD;
        imem[1]    = I_SUB;
        imem[2]    = I_OR;
        imem[3]    = I_AND;
        imem[5]    = I_BEQ;
        imem[6]    = 32'h00000000;
        imem[1023] = I_TOP;

        rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 10'd0;
        #12;
        chk_all("reset", 10'd0, NOP_W, 10'd0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;

        // Boot cycle: nothing is captured yet.
        tick(); chk_all("boot",   10'd0, NOP_W, 10'd0, 1'b0, 1'b0, 16'd0);
        tick(); chk_all("fetch0", 10'd1, I_ADD, 10'd0, 1'b1, 1'b0, 16'd1);
        tick(); chk_all("fetch1", 10'd2, I_SUB, 10'd1, 1'b1, 1'b0, 16'd2);

        // Stall for three cycles while the PC is 2.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(); chk_all("stall", 10'd2, I_SUB, 10'd1, 1'b1, 1'b0, 16'd2);
        end
        stall = 1'b0;
        tick(); chk_all("resume2", 10'd3, I_OR, 10'd2, 1'b1, 1'b0, 16'd3);

        // A branch together with a stall: the branch wins and IF/ID is flushed.
        branch_taken = 1'b1; stall = 1'b1; branch_target = 10'd5;
        tick(); chk_all("br_flush", 10'd5, NOP_W, 10'd2, 1'b0, 1'b0, 16'd3);
        branch_taken = 1'b0; stall = 1'b0; branch_target = 10'd0;
        tick(); chk_all("fetch5", 10'd6, I_BEQ, 10'd5, 1'b1, 1'b0, 16'd4);

        // A zero word at PC 6 halts fetch.
        tick(); chk_all("halt", 10'd6, NOP_W, 10'd5, 1'b0, 1'b1, 16'd4);
        branch_taken = 1'b1; branch_target = 10'd9;
        tick(); chk_all("halt_br", 10'd6, NOP_W, 10'd5, 1'b0, 1'b1, 16'd4);
        branch_taken = 1'b0; stall = 1'b1;
        tick(); chk_all("halt_hold", 10'd6, NOP_W, 10'd5, 1'b0, 1'b1, 16'd4);
        stall = 1'b0;

        // An asynchronous reset out of HALT, between edges.
        #3; rst_n = 1'b0; #1;
        chk_all("rst_halt", 10'd0, NOP_W, 10'd0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;
        tick(); chk_all("boot2",  10'd0, NOP_W, 10'd0, 1'b0, 1'b0, 16'd0);
        tick(); chk_all("f0_2",   10'd1, I_ADD, 10'd0, 1'b1, 1'b0, 16'd1);

        // Redirect to the top address, then the PC wraps to 0.
        branch_taken = 1'b1; branch_target = 10'd1023;
        tick(); chk_all("br_top", 10'd1023, NOP_W, 10'd0, 1'b0, 1'b0, 16'd1);
        branch_taken = 1'b0; branch_target = 10'd0;
        tick(); chk_all("f1023",  10'd0, I_TOP, 10'd1023, 1'b1, 1'b0, 16'd2);
        tick(); chk_all("wrap0",  10'd1, I_ADD, 10'd0, 1'b1, 1'b0, 16'd3);

        // Mid-run asynchronous reset, then restart from the reset PC.
        #3; rst_n = 1'b0; #1;
        chk_all("rst_mid", 10'd0, NOP_W, 10'd0, 1'b0, 1'b0, 16'd0);
        rst_n = 1'b1;
        tick(); chk_all("boot3",  10'd0, NOP_W, 10'd0, 1'b0, 1'b0, 16'd0);
        tick(); chk_all("f0_3",   10'd1, I_ADD, 10'd0, 1'b1, 1'b0, 16'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
